// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multi-cycle MIPS control unit.
//   Opcode/funct codes, ALU op codes, extension codes, datapath mux
//   encodings and FSM state codes. TRAP exists only when
//   MC_CTRL_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

  // opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct (IR[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // ALU operations
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_NOR  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_SLL  = 5'd10;
  localparam logic [4:0] ALU_SRL  = 5'd11;

  // immediate extension
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HIGH = 2'd2;

  // datapath mux encodings
  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JMP  = 2'd2;
  localparam logic [1:0] PC_RS   = 2'd3;
  localparam logic [1:0] RD_RT   = 2'd0;
  localparam logic [1:0] RD_RD   = 2'd1;
  localparam logic [1:0] RD_RA   = 2'd2;
  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MDR  = 2'd1;
  localparam logic [1:0] WD_PC   = 2'd2;
  localparam logic [1:0] SB_RT   = 2'd0;
  localparam logic [1:0] SB_FOUR = 2'd1;
  localparam logic [1:0] SB_IMM  = 2'd2;
  localparam logic [1:0] SB_BOFS = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: shared memory port handshake.
//   mem_req   request, held until mem_ready
//   mem_we    write request, meaningful only with mem_req
//   iord      address select (0 = PC, 1 = ALUOut)
//   mem_ready memory completes the current request this cycle
interface mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, mem_we, iord, input mem_ready);
  modport slave  (input mem_req, mem_we, iord, output mem_ready);
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// mc_ctrl_alu_dec: combinational opcode/funct -> ALU op / extension map.
//   opcode, funct in   instruction fields
//   aluctrl       out  ALU operation used in EXEC
//   ext_op        out  immediate extension used in EXEC
//   legal         out  opcode (and funct for R-type) is recognised
module mc_ctrl_alu_dec
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [ALUOP_W-1:0] aluctrl,
  output logic [1:0]         ext_op,
  output logic               legal
);

  always_comb begin
    aluctrl = ALUOP_W'(ALU_ADD);
    ext_op  = EXT_SIGN;
    legal   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:  aluctrl = ALUOP_W'(ALU_ADD);
          F_ADDU: aluctrl = ALUOP_W'(ALU_ADDU);
          F_SUB:  aluctrl = ALUOP_W'(ALU_SUB);
          F_SUBU: aluctrl = ALUOP_W'(ALU_SUBU);
          F_AND:  aluctrl = ALUOP_W'(ALU_AND);
          F_OR:   aluctrl = ALUOP_W'(ALU_OR);
          F_XOR:  aluctrl = ALUOP_W'(ALU_XOR);
          F_NOR:  aluctrl = ALUOP_W'(ALU_NOR);
          F_SLT:  aluctrl = ALUOP_W'(ALU_SLT);
          F_SLTU: aluctrl = ALUOP_W'(ALU_SLTU);
          F_SLL:  aluctrl = ALUOP_W'(ALU_SLL);
          F_SRL:  aluctrl = ALUOP_W'(ALU_SRL);
          F_JR:   aluctrl = ALUOP_W'(ALU_ADD);
          default: legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_ADDI, OP_LW, OP_SW: ;
      OP_BEQ, OP_BNE: aluctrl = ALUOP_W'(ALU_SUB);
      OP_ORI: begin
        aluctrl = ALUOP_W'(ALU_OR);
        ext_op  = EXT_ZERO;
      end
      OP_LUI: ext_op = EXT_HIGH;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit.
//   Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and mux
//   selects, handshakes with variable-latency memory through mem
//   (mc_ctrl_if.master) and counts retired instructions.
//   clk, rst_n (async, active low); opcode/funct from IR; zero from ALU.
//   Outputs: ir_we mdr_we pc_we pc_src reg_we reg_dst wd_sel alu_srca
//   alu_srcb ext_op aluctrl state retire retired_cnt.
//   MC_CTRL_ILLEGAL_TRAP_EN: adds TRAP state and the illegal output;
//   without it unknown instructions retire as NOPs.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_ctrl_if.master          mem,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               ir_we,
  output logic               mdr_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wd_sel,
  output logic               alu_srca,
  output logic [1:0]         alu_srcb,
  output logic [1:0]         ext_op,
  output logic [ALUOP_W-1:0] aluctrl,
  output logic [2:0]         state,
  output logic               retire,
  output logic [CNT_W-1:0]   retired_cnt
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  , output logic             illegal
`endif
);

  state_t st, nxt;
  logic [ALUOP_W-1:0] dec_alu;
  logic [1:0] dec_ext;
  logic legal, req, we, addr_sel, ill;

  mc_ctrl_alu_dec #(.ALUOP_W(ALUOP_W)) u_alu_dec (
    .opcode (opcode),
    .funct  (funct),
    .aluctrl(dec_alu),
    .ext_op (dec_ext),
    .legal  (legal)
  );

  wire is_r   = (opcode == OP_RTYPE);
  wire is_jr  = is_r && (funct == F_JR);
  wire is_j   = (opcode == OP_J) || (opcode == OP_JAL);
  wire is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
  wire is_lw  = (opcode == OP_LW);
  wire is_mem = is_lw || (opcode == OP_SW);

  always_comb begin
    nxt      = st;
    req      = 1'b0;
    we       = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    mdr_we   = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_SEQ;
    reg_we   = 1'b0;
    reg_dst  = RD_RT;
    wd_sel   = WD_ALU;
    alu_srca = 1'b0;
    alu_srcb = SB_FOUR;
    ext_op   = EXT_SIGN;
    aluctrl  = ALUOP_W'(ALU_ADD);
    retire   = 1'b0;
    ill      = 1'b0;
    case (st)
      S_FETCH: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm<<2) for a possible branch in EXEC
        alu_srcb = SB_BOFS;
        if (!legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          nxt = S_TRAP;
`else
          retire = 1'b1;
          nxt    = S_FETCH;
`endif
        end else if (is_j) begin
          pc_we  = 1'b1;
          pc_src = PC_JMP;
          retire = 1'b1;
          nxt    = S_FETCH;
          if (opcode == OP_JAL) begin
            reg_we  = 1'b1;
            reg_dst = RD_RA;
            wd_sel  = WD_PC;
          end
        end else if (is_jr) begin
          pc_we  = 1'b1;
          pc_src = PC_RS;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_srca = 1'b1;
        aluctrl  = dec_alu;
        ext_op   = dec_ext;
        alu_srcb = SB_IMM;
        if (is_r) begin
          alu_srcb = SB_RT;
          nxt      = S_WB;
        end else if (is_br) begin
          alu_srcb = SB_RT;
          pc_we    = (opcode == OP_BEQ) ? zero : ~zero;
          pc_src   = PC_BR;
          retire   = 1'b1;
          nxt      = S_FETCH;
        end else if (is_mem) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        req      = 1'b1;
        addr_sel = 1'b1;
        we       = ~is_lw;
        if (mem.mem_ready) begin
          if (is_lw) begin
            mdr_we = 1'b1;
            nxt    = S_WB;
          end else begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
        if (is_r) begin
          reg_dst = RD_RD;
        end else if (is_lw) begin
          wd_sel = WD_MDR;
        end
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        // exception vector arrives on the jump path
        ill    = 1'b1;
        pc_we  = 1'b1;
        pc_src = PC_JMP;
        nxt    = S_FETCH;
      end
`endif
      default: nxt = S_FETCH;
    endcase
    // state sits at FETCH during reset; keep every enable quiet until release
    if (!rst_n) begin
      req    = 1'b0;
      we     = 1'b0;
      ir_we  = 1'b0;
      mdr_we = 1'b0;
      pc_we  = 1'b0;
      reg_we = 1'b0;
      retire = 1'b0;
      ill    = 1'b0;
    end
  end

  assign mem.mem_req = req;
  assign mem.mem_we  = we;
  assign mem.iord    = addr_sel;
  assign state       = st;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal     = ill;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_FETCH;
      retired_cnt <= '0;
    end else begin
      st <= nxt;
      if (retire) retired_cnt <= retired_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl. Counter is built
// 4 bits wide so the wrap is reachable.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, funct;
  logic zero;
  logic ir_we, mdr_we, pc_we, reg_we, alu_srca, retire;
  logic [1:0] pc_src, reg_dst, wd_sel, alu_srcb, ext_op;
  logic [4:0] aluctrl;
  logic [2:0] state;
  logic [3:0] retired_cnt;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal;
`endif

  mc_ctrl_if mif ();

  mc_ctrl #(.ALUOP_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mif), .opcode(opcode), .funct(funct),
    .zero(zero), .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .ext_op(ext_op),
    .aluctrl(aluctrl), .state(state), .retire(retire),
    .retired_cnt(retired_cnt)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] exp_cnt;

  // per-cycle capture of the last instruction run
  logic [15:0] c_ir_we, c_mdr_we, c_pc_we, c_reg_we, c_retire;
  logic [15:0] c_req, c_we, c_iord, c_ill;
  logic [1:0]  c_pc_src [16];
  logic [1:0]  c_reg_dst [16];
  logic [1:0]  c_wd_sel [16];
  logic [1:0]  c_srcb [16];
  logic [1:0]  c_ext [16];
  logic [4:0]  c_alu [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from FETCH. mrp[i] = mem_ready in cycle i,
  // sp[3i+:3] = expected state in cycle i, ret = instruction retires.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int n, input logic [15:0] mrp,
                     input logic [47:0] sp, input logic ret);
    opcode = op;
    funct  = fn;
    zero   = z;
    c_ir_we = '0; c_mdr_we = '0; c_pc_we = '0; c_reg_we = '0; c_retire = '0;
    c_req = '0; c_we = '0; c_iord = '0; c_ill = '0;
    for (int i = 0; i < n; i++) begin
      mif.mem_ready = mrp[i];
      #2;
      chk($sformatf("%s_st%0d", tag, i), 32'(state), 32'(sp[3*i +: 3]));
      c_ir_we[i] = ir_we;   c_mdr_we[i] = mdr_we; c_pc_we[i] = pc_we;
      c_reg_we[i] = reg_we; c_retire[i] = retire;
      c_req[i] = mif.mem_req; c_we[i] = mif.mem_we; c_iord[i] = mif.iord;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      c_ill[i] = illegal;
`endif
      c_pc_src[i] = pc_src; c_reg_dst[i] = reg_dst; c_wd_sel[i] = wd_sel;
      c_srcb[i] = alu_srcb; c_ext[i] = ext_op; c_alu[i] = aluctrl;
      @(posedge clk);
      #1;
    end
    mif.mem_ready = 1'b0;
    if (ret) exp_cnt = exp_cnt + 4'd1;
    chk({tag, "_retire"}, 32'(c_retire), ret ? (32'd1 << (n - 1)) : 32'd0);
    chk({tag, "_cnt"}, 32'(retired_cnt), 32'(exp_cnt));
    #1;
    chk({tag, "_end_st"}, 32'(state), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    mif.mem_ready = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    exp_cnt = 4'd0;
    #3;
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_st", 32'(state), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_req", 32'(mif.mem_req), 32'd1);
    @(posedge clk); #1;
    chk("wait_st", 32'(state), 32'd0);
    chk("wait_req", 32'(mif.mem_req), 32'd1);
    rst_n = 1'b0;  // mid-request, asynchronous
    #1;
    chk("async_req", 32'(mif.mem_req), 32'd0);
    chk("async_ir_we", 32'(ir_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_st", 32'(state), 32'd0);
    chk("rel_cnt", 32'(retired_cnt), 32'd0);
    @(posedge clk); #1;

    // ADD: 0,1,2,4
    run("add", OP_RTYPE, 6'h20, 1'b0, 4, 16'hFFFF, 48'({3'd4, 3'd2, 3'd1, 3'd0}), 1'b1);
    chk("add_ir_we", 32'(c_ir_we), 32'h0001);
    chk("add_pc_we", 32'(c_pc_we), 32'h0001);
    chk("add_reg_we", 32'(c_reg_we), 32'h0008);
    chk("add_reg_dst", 32'(c_reg_dst[3]), 32'd1);
    chk("add_wd_sel", 32'(c_wd_sel[3]), 32'd0);
    chk("add_alu", 32'(c_alu[2]), 32'd0);
    chk("add_srcb", 32'(c_srcb[2]), 32'd0);
    chk("add_fetch_srcb", 32'(c_srcb[0]), 32'd1);
    chk("add_dec_srcb", 32'(c_srcb[1]), 32'd3);

    // SUB funct 0x22 -> ALU code 2
    run("sub", OP_RTYPE, 6'h22, 1'b0, 4, 16'hFFFF, 48'({3'd4, 3'd2, 3'd1, 3'd0}), 1'b1);
    chk("sub_alu", 32'(c_alu[2]), 32'd2);

    // LW, 3 wait cycles in FETCH and in MEM: 11 cycles
    run("lw", OP_LW, 6'h00, 1'b0, 11, 16'h0208,
        48'({3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0}), 1'b1);
    chk("lw_req", 32'(c_req), 32'h03CF);
    chk("lw_iord", 32'(c_iord), 32'h03C0);
    chk("lw_we", 32'(c_we), 32'h0000);
    chk("lw_ir_we", 32'(c_ir_we), 32'h0008);
    chk("lw_mdr_we", 32'(c_mdr_we), 32'h0200);
    chk("lw_wd_sel", 32'(c_wd_sel[10]), 32'd1);
    chk("lw_reg_dst", 32'(c_reg_dst[10]), 32'd0);
    chk("lw_ext", 32'(c_ext[5]), 32'd1);

    // SW: 0,1,2,3
    run("sw", OP_SW, 6'h00, 1'b0, 4, 16'hFFFF, 48'({3'd3, 3'd2, 3'd1, 3'd0}), 1'b1);
    chk("sw_we", 32'(c_we), 32'h0008);
    chk("sw_reg_we", 32'(c_reg_we), 32'h0000);

    // BEQ taken, BNE not taken (zero=1)
    run("beq", OP_BEQ, 6'h00, 1'b1, 3, 16'hFFFF, 48'({3'd2, 3'd1, 3'd0}), 1'b1);
    chk("beq_pc_we", 32'(c_pc_we), 32'h0005);
    chk("beq_pc_src", 32'(c_pc_src[2]), 32'd1);
    chk("beq_alu", 32'(c_alu[2]), 32'd2);
    run("bne", OP_BNE, 6'h00, 1'b1, 3, 16'hFFFF, 48'({3'd2, 3'd1, 3'd0}), 1'b1);
    chk("bne_pc_we", 32'(c_pc_we), 32'h0001);

    // JAL, JR
    run("jal", OP_JAL, 6'h00, 1'b0, 2, 16'hFFFF, 48'({3'd1, 3'd0}), 1'b1);
    chk("jal_pc_src", 32'(c_pc_src[1]), 32'd2);
    chk("jal_reg_dst", 32'(c_reg_dst[1]), 32'd2);
    chk("jal_wd_sel", 32'(c_wd_sel[1]), 32'd2);
    chk("jal_reg_we", 32'(c_reg_we), 32'h0002);
    run("jr", OP_RTYPE, 6'h08, 1'b0, 2, 16'hFFFF, 48'({3'd1, 3'd0}), 1'b1);
    chk("jr_pc_src", 32'(c_pc_src[1]), 32'd3);
    chk("jr_reg_we", 32'(c_reg_we), 32'h0000);

    // ORI (zero ext, OR), LUI (high ext)
    run("ori", OP_ORI, 6'h00, 1'b0, 4, 16'hFFFF, 48'({3'd4, 3'd2, 3'd1, 3'd0}), 1'b1);
    chk("ori_alu", 32'(c_alu[2]), 32'd5);
    chk("ori_ext", 32'(c_ext[2]), 32'd0);
    chk("ori_srcb", 32'(c_srcb[2]), 32'd2);
    chk("ori_reg_dst", 32'(c_reg_dst[3]), 32'd0);
    run("lui", OP_LUI, 6'h00, 1'b0, 4, 16'hFFFF, 48'({3'd4, 3'd2, 3'd1, 3'd0}), 1'b1);
    chk("lui_ext", 32'(c_ext[2]), 32'd2);

    // unlisted opcode and funct
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    run("ill_op", 6'h3F, 6'h00, 1'b0, 3, 16'hFFFF, 48'({3'd5, 3'd1, 3'd0}), 1'b0);
    chk("ill_op_flag", 32'(c_ill), 32'h0004);
    chk("ill_op_pc_we", 32'(c_pc_we), 32'h0005);
    chk("ill_op_pc_src", 32'(c_pc_src[2]), 32'd2);
    run("ill_fn", OP_RTYPE, 6'h3F, 1'b0, 3, 16'hFFFF, 48'({3'd5, 3'd1, 3'd0}), 1'b0);
    chk("ill_fn_flag", 32'(c_ill), 32'h0004);
`else
    run("ill_op", 6'h3F, 6'h00, 1'b0, 2, 16'hFFFF, 48'({3'd1, 3'd0}), 1'b1);
    chk("ill_op_pc_we", 32'(c_pc_we), 32'h0001);
    chk("ill_op_reg_we", 32'(c_reg_we), 32'h0000);
    run("ill_fn", OP_RTYPE, 6'h3F, 1'b0, 2, 16'hFFFF, 48'({3'd1, 3'd0}), 1'b1);
    chk("ill_fn_pc_we", 32'(c_pc_we), 32'h0001);
`endif

    // run J repeatedly so the 4-bit counter wraps
    for (int k = 0; k < 10; k++)
      run("j", OP_J, 6'h00, 1'b0, 2, 16'hFFFF, 48'({3'd1, 3'd0}), 1'b1);

    // reset in EXEC: partial instruction must not retire
    opcode = OP_RTYPE;
    funct = 6'h20;
    mif.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("part_exec_st", 32'(state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("part_retire", 32'(retire), 32'd0);
    chk("part_st", 32'(state), 32'd0);
    chk("part_cnt", 32'(retired_cnt), 32'd0);
    @(posedge clk); #1;
    chk("part_hold_reg_we", 32'(reg_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
